// File: rtl/edge_detector_bank.sv
// edge_detector_bank: per-channel synchroniser, debounce filter, edge pulses and sticky W1C flags
module edge_detector_bank #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CNT = 4,
  parameter MODE = "NORMAL"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] rise_flag,
  output logic [WIDTH-1:0] fall_flag,
  output logic             any_edge
);
  localparam int CW = FILTER_CNT > 1 ? $clog2(FILTER_CNT) : 1;
  localparam bit FAST = MODE == "FAST";
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] smp, accept, level_q, level_d, rise_d, fall_d, rise_q, fall_q;
  logic [WIDTH-1:0] rise_flag_q, rise_flag_d, fall_flag_q, fall_flag_d;
  always_comb begin
    sync_d[0] = in;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    smp = sync_q[SYNC_STAGES-1];
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = smp[i] != level_q[i] && cnt_q[i] == CW'(FILTER_CNT - 1);
      cnt_d[i] = (smp[i] == level_q[i] || accept[i]) ? '0 : cnt_q[i] + 1'b1;
    end
    level_d = level_q ^ accept;
    rise_d = accept & smp & en;
    fall_d = accept & ~smp & en;
    rise = FAST ? (rst ? '0 : rise_d) : rise_q;
    fall = FAST ? (rst ? '0 : fall_d) : fall_q;
    rise_flag_d = rise | (rise_flag_q & ~clr);
    fall_flag_d = fall | (fall_flag_q & ~clr);
    any_edge = |(rise | fall);
    level = level_q;
    rise_flag = rise_flag_q;
    fall_flag = fall_flag_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      level_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      rise_flag_q <= '0;
      fall_flag_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      rise_flag_q <= rise_flag_d;
      fall_flag_q <= fall_flag_d;
    end
  end
endmodule
